// File: rtl/dsp_mac_sequencer_if.sv
// Signal bundle between the MAC sequencer, its job/operand/result clients and one DSP slice.
// master = sequencer side; slave = environment side (job source, operand feed, result sink, DSP).
interface dsp_mac_sequencer_if #(
    parameter int AW    = 30,
    parameter int BW    = 18,
    parameter int PW    = 48,
    parameter int LEN_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LEN_W-1:0] cfg_len;
    logic [PW-1:0]    cfg_bias;

    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_a;
    logic [BW-1:0]    in_b;

    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_p;
    logic             busy;

    logic             dsp_enable;
    logic             dsp_rst;
    logic [AW-1:0]    dsp_a;
    logic [BW-1:0]    dsp_b;
    logic [PW-1:0]    dsp_c;
    logic [3:0]       dsp_alumode;
    logic [4:0]       dsp_inmode;
    logic [8:0]       dsp_opmode;
    logic [PW-1:0]    dsp_p;

    modport master (
        input  cfg_valid, cfg_len, cfg_bias, in_valid, in_a, in_b, out_ready, dsp_p,
        output cfg_ready, in_ready, out_valid, out_p, busy,
               dsp_enable, dsp_rst, dsp_a, dsp_b, dsp_c, dsp_alumode, dsp_inmode, dsp_opmode
    );

    modport slave (
        output cfg_valid, cfg_len, cfg_bias, in_valid, in_a, in_b, out_ready, dsp_p,
        input  cfg_ready, in_ready, out_valid, out_p, busy,
               dsp_enable, dsp_rst, dsp_a, dsp_b, dsp_c, dsp_alumode, dsp_inmode, dsp_opmode
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Streams N signed (a,b) beats into one DSP slice as P = bias + sum(a*b), returns P on valid/ready.
// Latency: out_valid rises INPUTREG+DSPPIPEREG+2 edges after the last beat (or the N=0 job accept).
// Backpressure: in_valid gaps issue HOLD; out_ready low holds the result and blocks new jobs.
module dsp_mac_sequencer #(
    parameter int AW         = 30,
    parameter int BW         = 18,
    parameter int PW         = 48,
    parameter int INPUTREG   = 1,
    parameter int DSPPIPEREG = 0,
    parameter int LEN_W      = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    dsp_mac_sequencer_if.master bus
);
    localparam int D   = INPUTREG + DSPPIPEREG;
    localparam int L   = D + 1;
    localparam int DCW = $clog2(L + 1);

    localparam logic [8:0] op_first = 9'b110000101;
    localparam logic [8:0] op_acc   = 9'b000100101;
    localparam logic [8:0] op_hold  = 9'b000100000;
    localparam logic [8:0] op_bias  = 9'b110000000;

    typedef enum logic [1:0] {st_idle, st_feed, st_drain, st_result} state_t;

    state_t           state, state_nx;
    logic [LEN_W-1:0] beats_left;
    logic             first_beat;
    logic [DCW-1:0]   drain_cnt;
    logic [D:0][8:0]  op_pipe;
    logic [AW-1:0]    a_q;
    logic [BW-1:0]    b_q;
    logic [PW-1:0]    c_q;
    logic [PW-1:0]    p_q;
    logic             out_vld_q;
    logic             dsp_rst_q;
    logic             dsp_en_q;

    logic             cfg_rdy;
    logic             in_rdy;
    logic [8:0]       op_issue;
    logic             cfg_fire;
    logic             beat_fire;
    logic             drain_done;
    logic             out_fire;

    assign cfg_fire   = bus.cfg_valid && cfg_rdy;
    assign beat_fire  = bus.in_valid && in_rdy;
    assign drain_done = (state == st_drain) && (drain_cnt == DCW'(L));
    assign out_fire   = out_vld_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= st_idle;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            st_idle:   if (cfg_fire) state_nx = (bus.cfg_len == '0) ? st_drain : st_feed;
            st_feed:   if (beat_fire && beats_left == LEN_W'(1)) state_nx = st_drain;
            st_drain:  if (drain_done) state_nx = st_result;
            st_result: if (out_fire) state_nx = st_idle;
            default:   state_nx = st_idle;
        endcase
    end

    // Any cycle without a beat (or an N=0 bias load) issues HOLD so bubbles leave P untouched.
    always_comb begin
        cfg_rdy  = (state == st_idle);
        in_rdy   = (state == st_feed);
        op_issue = op_hold;
        if (cfg_fire && bus.cfg_len == '0) op_issue = op_bias;
        else if (beat_fire)                op_issue = first_beat ? op_first : op_acc;
    end

    // op_pipe[0] is loaded on the same edge as dsp_a/b; D more stages meet the slice's A/B/M regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_pipe    <= {(D + 1){op_hold}};
            beats_left <= '0;
            first_beat <= 1'b0;
            drain_cnt  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            out_vld_q  <= 1'b0;
            dsp_rst_q  <= 1'b1;
            dsp_en_q   <= 1'b0;
        end else begin
            dsp_rst_q <= 1'b0;
            dsp_en_q  <= 1'b1;
            for (int i = D; i > 0; i--) op_pipe[i] <= op_pipe[i-1];
            op_pipe[0] <= op_issue;

            if (cfg_fire) begin
                c_q        <= bus.cfg_bias;
                beats_left <= bus.cfg_len;
                first_beat <= 1'b1;
                if (bus.cfg_len == '0) begin
                    a_q <= '0;
                    b_q <= '0;
                end
            end
            if (beat_fire) begin
                a_q        <= bus.in_a;
                b_q        <= bus.in_b;
                beats_left <= beats_left - 1'b1;
                first_beat <= 1'b0;
            end

            drain_cnt <= (state == st_drain) ? drain_cnt + 1'b1 : '0;

            if (drain_done) begin
                p_q       <= bus.dsp_p;
                out_vld_q <= 1'b1;
            end else if (out_fire) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready   = cfg_rdy;
    assign bus.in_ready    = in_rdy;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_p       = p_q;
    assign bus.busy        = (state != st_idle);
    assign bus.dsp_enable  = dsp_en_q;
    assign bus.dsp_rst     = dsp_rst_q;
    assign bus.dsp_a       = a_q;
    assign bus.dsp_b       = b_q;
    assign bus.dsp_c       = c_q;
    assign bus.dsp_alumode = 4'b0000;
    assign bus.dsp_inmode  = 5'b00000;
    assign bus.dsp_opmode  = op_pipe[D];
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP slice (A/B regs, no M reg, P reg) plus
// a sum-of-products reference; directed jobs followed by randomized jobs.
module tb_dsp_mac_sequencer;
    localparam int AW    = 30;
    localparam int BW    = 18;
    localparam int PW    = 48;
    localparam int LEN_W = 8;

    localparam logic [8:0] OP_FIRST = 9'b110000101;
    localparam logic [8:0] OP_ACC   = 9'b000100101;
    localparam logic [8:0] OP_HOLD  = 9'b000100000;
    localparam logic [8:0] OP_BIAS  = 9'b110000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp_mac_sequencer_if #(.AW(AW), .BW(BW), .PW(PW), .LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(
        .AW(AW), .BW(BW), .PW(PW), .INPUTREG(1), .DSPPIPEREG(0), .LEN_W(LEN_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DSP slice model: A/B input registers, combinational multiplier, P output register.
    logic signed [AW-1:0] a_r;
    logic signed [BW-1:0] b_r;
    logic [PW-1:0]        p_r;
    logic signed [PW-1:0] m_ext;
    assign m_ext   = a_r * b_r;
    assign bus.dsp_p = p_r;

    function automatic logic [PW-1:0] alu(input logic [8:0] op, input logic [PW-1:0] c,
                                          input logic [PW-1:0] p, input logic [PW-1:0] m);
        logic [PW-1:0] w, z, xy;
        w  = (op[8:7] == 2'b11)  ? c : '0;
        z  = (op[6:4] == 3'b010) ? p : '0;
        xy = (op[3:2] == 2'b01 && op[1:0] == 2'b01) ? m : '0;
        return w + z + xy;
    endfunction

    always @(posedge clk) begin
        if (bus.dsp_rst) begin
            a_r <= '0;
            b_r <= '0;
            p_r <= '0;
        end else if (bus.dsp_enable) begin
            a_r <= bus.dsp_a;
            b_r <= bus.dsp_b;
            p_r <= alu(bus.dsp_opmode, bus.dsp_c, p_r, m_ext);
        end
    end

    // Expected op on dsp_opmode: the op implied by each edge's handshakes, two edges later.
    logic [8:0] op_d1, op_d2;
    int         beat_no;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_d1   <= OP_HOLD;
            op_d2   <= OP_HOLD;
            beat_no <= 0;
        end else begin
            op_d2 <= op_d1;
            if (bus.cfg_valid && bus.cfg_ready) begin
                beat_no <= 0;
                op_d1   <= (bus.cfg_len == '0) ? OP_BIAS : OP_HOLD;
            end else if (bus.in_valid && bus.in_ready) begin
                op_d1   <= (beat_no == 0) ? OP_FIRST : OP_ACC;
                beat_no <= beat_no + 1;
            end else begin
                op_d1 <= OP_HOLD;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("opmode", bus.dsp_opmode, op_d2);
            chk("alumode", bus.dsp_alumode, 4'b0000);
            chk("inmode", bus.dsp_inmode, 5'b00000);
        end
    end

    logic signed [AW-1:0] ja [256];
    logic signed [BW-1:0] jb [256];

    task automatic send_cfg(input int n, input logic [PW-1:0] bias, input string tag);
        int t;
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_len   = LEN_W'(n);
        bus.cfg_bias  = bias;
        t = 0;
        while (!bus.cfg_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " cfg_ready"}, bus.cfg_ready, 1);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk({tag, " dsp_c"}, bus.dsp_c, bias);
    endtask

    task automatic send_beat(input int k, input int gap, input string tag);
        int t;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = ja[k];
        bus.in_b     = jb[k];
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [PW-1:0] bias, input int gap,
                           input int hold, input string tag);
        logic [PW-1:0]        exp_p;
        logic signed [PW-1:0] prod;
        int t, c;
        exp_p = bias;
        for (int k = 0; k < n; k++) begin
            prod  = ja[k] * jb[k];
            exp_p = exp_p + prod;
        end
        send_cfg(n, bias, tag);
        c = cyc;
        for (int k = 0; k < n; k++) begin
            send_beat(k, gap, tag);
            c = cyc;
        end
        t = 0;
        while (!bus.out_valid && t < 50) begin
            if (n == 0) chk({tag, " no in_ready"}, bus.in_ready, 0);
            @(negedge clk);
            t++;
        end
        chk({tag, " out_valid"}, bus.out_valid, 1);
        chk({tag, " latency"}, cyc - c, 3);
        chk({tag, " out_p"}, bus.out_p, exp_p);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " held out_p"}, bus.out_p, exp_p);
            chk({tag, " held out_valid"}, bus.out_valid, 1);
            chk({tag, " held cfg_ready"}, bus.cfg_ready, 0);
            chk({tag, " held in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid clear"}, bus.out_valid, 0);
        chk({tag, " idle"}, bus.busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_len   = '0;
        bus.cfg_bias  = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_p", bus.out_p, 0);
        chk("rst dsp_a", bus.dsp_a, 0);
        chk("rst dsp_b", bus.dsp_b, 0);
        chk("rst dsp_c", bus.dsp_c, 0);
        chk("rst opmode", bus.dsp_opmode, OP_HOLD);
        chk("rst dsp_rst", bus.dsp_rst, 1);
        chk("rst dsp_enable", bus.dsp_enable, 0);
        chk("rst busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst dsp_rst", bus.dsp_rst, 0);
        chk("post-rst dsp_enable", bus.dsp_enable, 1);
        mon_en = 1'b1;

        ja[0] = 1; jb[0] = 2; ja[1] = 3; jb[1] = 4; ja[2] = 5; jb[2] = 6;
        run_job(3, 48'd2, 0, 0, "t1 b2b");
        run_job(3, 48'd2, 2, 0, "t2 gaps");

        ja[0] = -3; jb[0] = 7;
        run_job(1, 48'd0, 0, 0, "t3 neg");

        run_job(0, 48'd5, 0, 0, "t4 n0");

        ja[0] = 100; jb[0] = -9; ja[1] = 11; jb[1] = 13;
        run_job(2, 48'd7, 1, 4, "t5 hold");

        // Abandon an N=4 job after two beats.
        ja[0] = 9; jb[0] = 9; ja[1] = 8; jb[1] = 8;
        send_cfg(4, 48'd77, "t6 abort");
        send_beat(0, 0, "t6 abort");
        send_beat(1, 0, "t6 abort");
        rst_n = 1'b0;
        #1;
        chk("t6 rst out_valid", bus.out_valid, 0);
        chk("t6 rst out_p", bus.out_p, 0);
        chk("t6 rst dsp_a", bus.dsp_a, 0);
        chk("t6 rst dsp_b", bus.dsp_b, 0);
        chk("t6 rst dsp_c", bus.dsp_c, 0);
        chk("t6 rst opmode", bus.dsp_opmode, OP_HOLD);
        chk("t6 rst dsp_rst", bus.dsp_rst, 1);
        chk("t6 rst dsp_enable", bus.dsp_enable, 0);
        chk("t6 rst busy", bus.busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6 no out_valid", bus.out_valid, 0);
            chk("t6 dsp_enable", bus.dsp_enable, 1);
        end
        ja[0] = 2; jb[0] = 2; ja[1] = 3; jb[1] = 3;
        run_job(2, 48'd1, 0, 0, "t6 next");

        for (int j = 0; j < 20; j++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int k = 0; k < n; k++) begin
                ja[k] = AW'($urandom());
                jb[k] = BW'($urandom());
            end
            run_job(n, PW'({$urandom(), $urandom()}), $urandom_range(0, 2),
                    $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
